// File: rtl/reqack_rr_server.sv
// rtl/reqack_rr_server.sv - round-robin four-phase req/ack server with abort and per-channel watchdogs
module reqack_rr_server #(
    parameter int NCH = 4,
    parameter int SVC = 2,
    parameter int MAX = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NCH-1:0]         req,
    input  logic                   intrpt,
    input  logic                   clr_err,
    output logic [NCH-1:0]         ack,
    output logic                   done,
    output logic                   abort,
    output logic                   busy,
    output logic [$clog2(NCH)-1:0] grant_id,
    output logic [NCH-1:0]         wait_err,
    output logic                   proto_err
);
    localparam int GW = $clog2(NCH);
    localparam int WW = $clog2(MAX + 1);
    localparam int CW = (SVC > 1) ? $clog2(SVC) : 1;

    typedef enum logic [1:0] {IDLE, SERVE, ACK} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic            abort_pend;
    logic            found_hi, found_lo, found, grant_now;
    logic [GW-1:0]   pick_hi, pick_lo, pick;
    logic [WW-1:0]   wd [NCH];

    // Round-robin search: prefer channels above the pointer, otherwise wrap to the lowest requester
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (req[i] && (GW'(i) > ptr) && !found_hi) begin
                found_hi = 1'b1;
                pick_hi  = GW'(i);
            end
            if (req[i] && (GW'(i) <= ptr) && !found_lo) begin
                found_lo = 1'b1;
                pick_lo  = GW'(i);
            end
        end
    end

    assign found     = found_hi | found_lo;
    assign pick      = found_hi ? pick_hi : pick_lo;
    assign grant_now = (state == IDLE) && !intrpt && found;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: intrpt cuts a service short, ACK always lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_now) state_nxt = SERVE;
            SERVE:   if (intrpt || (cnt == '0)) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping, service countdown and abort capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_id   <= '0;
            ptr        <= GW'(NCH - 1);
            cnt        <= '0;
            abort_pend <= 1'b0;
        end else if (grant_now) begin
            grant_id   <= pick;
            ptr        <= pick;
            cnt        <= CW'(SVC - 1);
            abort_pend <= 1'b0;
        end else if (state == SERVE) begin
            if (intrpt) begin
                abort_pend <= 1'b1;
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Watchdogs and sticky error flags; a set event beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                wd[i] <= '0;
            end
            wait_err  <= '0;
            proto_err <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!req[i] || (grant_now && (pick == GW'(i))) || (busy && (grant_id == GW'(i)))) begin
                    wd[i] <= '0;
                    if (clr_err) wait_err[i] <= 1'b0;
                end else begin
                    if (wd[i] != WW'(MAX)) wd[i] <= wd[i] + WW'(1);
                    if (wd[i] >= WW'(MAX - 1)) wait_err[i] <= 1'b1;
                    else if (clr_err)          wait_err[i] <= 1'b0;
                end
            end
            if ((state == SERVE) && !req[grant_id]) proto_err <= 1'b1;
            else if (clr_err)                       proto_err <= 1'b0;
        end
    end

    assign busy  = (state != IDLE);
    assign done  = (state == ACK);
    assign abort = (state == ACK) && abort_pend;
    assign ack   = (state == ACK) ? (NCH'(1) << grant_id) : '0;

endmodule

// File: tb/tb_reqack_rr_server.sv
// tb/tb_reqack_rr_server.sv - self-checking bench for reqack_rr_server against a timestamp model
module tb_reqack_rr_server;
    localparam int NCH = 4;
    localparam int SVC = 2;
    localparam int MAX = 5;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [NCH-1:0] req = '0;
    logic           intrpt = 1'b0;
    logic           clr_err = 1'b0;
    logic [NCH-1:0] ack;
    logic           done, abort, busy;
    logic [1:0]     grant_id;
    logic [NCH-1:0] wait_err;
    logic           proto_err;

    reqack_rr_server #(.NCH(NCH), .SVC(SVC), .MAX(MAX)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .intrpt(intrpt), .clr_err(clr_err),
        .ack(ack), .done(done), .abort(abort), .busy(busy), .grant_id(grant_id),
        .wait_err(wait_err), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: a service is described by its grant edge and the edge at which its ack cycle starts
    bit             m_active, m_abort, m_proto;
    int             m_ch, m_ptr, m_gnt, m_ack_at;
    int             n = 0;
    int             age [NCH];
    logic [NCH-1:0] m_werr;
    int             gnt_log [$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_abort  = 0;
        m_proto  = 0;
        m_ch     = 0;
        m_ptr    = NCH - 1;
        m_gnt    = 0;
        m_ack_at = 0;
        m_werr   = '0;
        for (int i = 0; i < NCH; i++) age[i] = 0;
    endtask

    task automatic model_edge();
        int             pick;
        bit             granted;
        bit             was_active;
        int             was_ch;
        logic [NCH-1:0] wset;
        bit             pset;
        pick       = -1;
        granted    = 0;
        was_active = m_active;
        was_ch     = m_ch;
        wset       = '0;
        pset       = 0;
        n++;
        if (!m_active) begin
            if (!intrpt) begin
                for (int k = 1; k <= NCH; k++) begin
                    if (pick < 0 && req[(m_ptr + k) % NCH]) pick = (m_ptr + k) % NCH;
                end
            end
            if (pick >= 0) begin
                m_active = 1;
                m_ch     = pick;
                m_ptr    = pick;
                m_gnt    = n;
                m_ack_at = n + SVC;
                m_abort  = 0;
                granted  = 1;
                gnt_log.push_back(pick);
            end
        end else if (n > m_ack_at) begin
            m_active = 0;
        end else begin
            if (!req[m_ch]) pset = 1;
            if (intrpt) begin
                m_ack_at = n;
                m_abort  = 1;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!req[i] || (granted && pick == i) || (was_active && was_ch == i)) begin
                age[i] = 0;
            end else begin
                if (age[i] < MAX) age[i]++;
                if (age[i] >= MAX) wset[i] = 1'b1;
            end
        end
        m_werr  = wset | (clr_err ? '0 : m_werr);
        m_proto = pset | (clr_err ? 1'b0 : m_proto);
    endtask

    task automatic compare();
        logic [NCH-1:0] a_exp;
        a_exp = (m_active && n == m_ack_at) ? NCH'(1 << m_ch) : '0;
        chk("ack", ack, a_exp);
        chk("done", done, a_exp != 0);
        chk("abort", abort, (a_exp != 0) && m_abort);
        chk("busy", busy, m_active);
        chk("grant_id", grant_id, m_ch);
        chk("wait_err", wait_err, m_werr);
        chk("proto_err", proto_err, m_proto);
    endtask

    // One clock: model and compare after the rising edge, requesters retire acked reqs at the falling edge
    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_edge();
        #1 compare();
        @(negedge clk);
        req = req & ~ack;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare();
        chk("rst_async_busy", busy, 0);
        chk("rst_async_ack", ack, 0);
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_gid", grant_id, 0);
        chk("reset_werr", wait_err, 0);
        reset_n = 1'b1;

        // Single request on channel 1
        req = 4'b0010;
        tick(); chk("s1_gid", grant_id, 1); chk("s1_busy", busy, 1);
        tick(); chk("s1_ack_early", ack, 0);
        tick(); chk("s1_ack", ack, 4'b0010); chk("s1_done", done, 1);
        tick(); chk("s1_ack_end", ack, 0); chk("s1_idle", busy, 0); chk("s1_werr", wait_err, 0);

        // All four request together after a fresh reset
        do_reset();
        gnt_log.delete();
        req = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 4) chk("s2_werr_t4", wait_err, 4'b1100);
        end
        chk("s2_ngrant", gnt_log.size(), 4);
        for (int k = 0; k < 4 && k < gnt_log.size(); k++) chk("s2_order", gnt_log[k], k);

        // Wrap-around search after serving channel 2
        gnt_log.delete();
        req = 4'b0100;
        repeat (4) tick();
        req = 4'b0101;
        repeat (8) tick();
        chk("s3_ngrant", gnt_log.size(), 3);
        for (int k = 0; k < 3 && k < gnt_log.size(); k++) chk("s3_order", gnt_log[k], (k == 1) ? 0 : 2);

        // Interrupt during service, then held intrpt blocks new grants
        req = 4'b1000;
        tick(); chk("s4_gid", grant_id, 3);
        intrpt = 1'b1;
        tick(); chk("s4_ack", ack, 4'b1000); chk("s4_abort", abort, 1); chk("s4_done", done, 1);
        req[0] = 1'b1;
        repeat (4) tick();
        chk("s4_blocked", busy, 0);
        intrpt = 1'b0;
        repeat (4) tick();

        // Protocol error: req dropped during its own service, then cleared
        req = 4'b0100;
        tick();
        req[2] = 1'b0;
        tick(); chk("s5_proto", proto_err, 1);
        tick(); chk("s5_ack", ack, 4'b0100);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("s5_proto_clr", proto_err, 0);
        chk("s5_werr_clr", wait_err, 0);

        // Reset in the middle of a service, held request served fresh afterwards
        req = 4'b0010;
        tick();
        tick();
        do_reset();
        tick(); chk("s6_gid", grant_id, 1); chk("s6_busy", busy, 1);
        repeat (3) tick();

        // Randomized traffic with interrupts, clears and occasional resets
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int i = 0; i < NCH; i++) begin
                if (!req[i] && $urandom_range(3) == 0)       req[i] = 1'b1;
                else if (req[i] && $urandom_range(63) == 0)  req[i] = 1'b0;
            end
            intrpt  = ($urandom_range(9) == 0);
            clr_err = ($urandom_range(15) == 0);
            if ($urandom_range(299) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
